// File: rtl/i2c_rx_deserializer.sv
// I2C read-path deserializer: samples SDA on SCL rises, builds MSB-first bytes, commits them to a show-ahead RX FIFO.
// Byte visible 1 cycle after commit; a commit into a full FIFO is dropped (sticky rx_overflow); optional I2C_RX_GLITCH_FILTER_EN.
module i2c_rx_deserializer #(
    parameter int DEPTH      = 16,
    parameter int FILTER_LEN = 3
) (
    input  logic                     core_clk,
    input  logic                     rst_n,
    input  logic                     scl_in,
    input  logic                     sda_in,
    input  logic                     converter_enable,
    input  logic                     fifo_rx_enable,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic [7:0]               rx_data,
    output logic                     rx_empty,
    output logic                     rx_full,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     rx_overflow,
    output logic                     byte_ready,
    output logic                     frame_abort
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("FILTER_LEN must be at least 1");
    end

    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_s, sda_s, scl_d_q, fre_d_q;
    logic        scl_rise, commit, push, pop, set_ovf, abort_d;
    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        frame_abort_q, ovf_q;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef I2C_RX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic          scl_f_q, sda_f_q;
    logic [FW-1:0] scl_cnt_q, sda_cnt_q;

    // Output follows the synchronized line only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
        end else begin
            if (scl_sync_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FW'(FILTER_LEN - 1)) begin
                scl_f_q   <= scl_sync_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 1'b1;
            end
            if (sda_sync_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FW'(FILTER_LEN - 1)) begin
                sda_f_q   <= sda_sync_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 1'b1;
            end
        end
    end

    assign scl_s = scl_f_q;
    assign sda_s = sda_f_q;
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    assign scl_rise = scl_s & ~scl_d_q;
    assign commit   = fifo_rx_enable & ~fre_d_q;

    assign rx_count = wr_ptr_q - rd_ptr_q;
    assign rx_empty = (wr_ptr_q == rd_ptr_q);
    assign rx_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rx_data  = rx_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign pop      = rd_en & ~rx_empty;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        abort_d   = 1'b0;
        push      = 1'b0;
        set_ovf   = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = 4'd0;
                if (converter_enable) state_d = SHIFT;
            end
            SHIFT: begin
                if (!converter_enable) begin
                    abort_d   = 1'b1;
                    shift_d   = 8'h00;
                    bit_cnt_d = 4'd0;
                    state_d   = IDLE;
                end else if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) state_d = HOLD;
                end
            end
            HOLD: begin
                // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
                if (commit) begin
                    if (!rx_full || pop) push = 1'b1;
                    else                 set_ovf = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            scl_d_q       <= 1'b1;
            fre_d_q       <= 1'b0;
            state_q       <= IDLE;
            shift_q       <= 8'h00;
            bit_cnt_q     <= 4'd0;
            frame_abort_q <= 1'b0;
            ovf_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            scl_d_q       <= scl_s;
            fre_d_q       <= fifo_rx_enable;
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_abort_q <= abort_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            if (set_ovf)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    assign rx_overflow = ovf_q;
    assign byte_ready  = (state_q == HOLD);
    assign frame_abort = frame_abort_q;
endmodule

// File: tb/tb_i2c_rx_deserializer.sv
// Directed bench for i2c_rx_deserializer: assembly, fill/overflow, simultaneous push/pop, abort, reset, glitch.
module tb_i2c_rx_deserializer;
    logic       core_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_in = 1'b0, sda_in = 1'b1;
    logic       converter_enable = 1'b0, fifo_rx_enable = 1'b0;
    logic       rd_en = 1'b0, ovf_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty, rx_full, rx_overflow, byte_ready, frame_abort;
    logic [4:0] rx_count;
    int         errors = 0;
    int         checks = 0;

    i2c_rx_deserializer #(.DEPTH(16), .FILTER_LEN(3)) dut (
        .core_clk(core_clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
        .converter_enable(converter_enable), .fifo_rx_enable(fifo_rx_enable),
        .rd_en(rd_en), .ovf_clr(ovf_clr), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_full(rx_full), .rx_count(rx_count), .rx_overflow(rx_overflow),
        .byte_ready(byte_ready), .frame_abort(frame_abort)
    );

    always #5 core_clk = ~core_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic scl_pulse(input logic b);
        sda_in = b;
        tick(4);
        scl_in = 1'b1;
        tick(4);
        scl_in = 1'b0;
        tick(4);
    endtask

    task automatic assemble(input logic [7:0] b);
        converter_enable = 1'b1;
        tick(2);
        for (int i = 7; i >= 0; i--) scl_pulse(b[i]);
        tick(2);
        converter_enable = 1'b0;
        tick(1);
    endtask

    task automatic commit_byte();
        fifo_rx_enable = 1'b1;
        tick(2);
        fifo_rx_enable = 1'b0;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        assemble(b);
        commit_byte();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", rx_empty); end
        checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", rx_full); end
        checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", rx_count); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", rx_overflow); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got=%b exp=0", byte_ready); end
        checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", frame_abort); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_byte_assembly();
        assemble(8'hA5);
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL asm_byte_ready got=%b exp=1", byte_ready); end
        commit_byte();
        checks++; if (rx_count !== 5'd1) begin errors++; $display("FAIL asm_count got=%0d exp=1", rx_count); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL asm_data got=%h exp=a5", rx_data); end
        checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL asm_empty got=%b exp=0", rx_empty); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL asm_byte_ready_clr got=%b exp=0", byte_ready); end
        pop_one();
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL asm_pop_empty got=%b exp=1", rx_empty); end
        pop_one();
        checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL asm_pop_when_empty got=%0d exp=0", rx_count); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", rx_full); end
        checks++; if (rx_count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", rx_count); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got=%b exp=0", rx_overflow); end
        send_byte(8'hFF);
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", rx_overflow); end
        checks++; if (rx_count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", rx_count); end
        checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", rx_full); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL ovf_head got=%h exp=00", rx_data); end
        tick(3);
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", rx_overflow); end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", rx_overflow); end
    endtask

    task automatic test_simul_full();
        logic [7:0] exp;
        assemble(8'h55);
        fifo_rx_enable = 1'b1;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(1);
        fifo_rx_enable = 1'b0;
        tick(2);
        checks++; if (rx_count !== 5'd16) begin errors++; $display("FAIL simfull_count got=%0d exp=16", rx_count); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL simfull_ovf got=%b exp=0", rx_overflow); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'(i + 1) : 8'h55;
            checks++; if (rx_data !== exp) begin errors++; $display("FAIL drain_%0d got=%h exp=%h", i, rx_data, exp); end
            pop_one();
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", rx_empty); end
    endtask

    task automatic test_simul_empty();
        assemble(8'h66);
        fifo_rx_enable = 1'b1;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(1);
        fifo_rx_enable = 1'b0;
        tick(2);
        checks++; if (rx_count !== 5'd1) begin errors++; $display("FAIL simempty_count got=%0d exp=1", rx_count); end
        checks++; if (rx_data !== 8'h66) begin errors++; $display("FAIL simempty_data got=%h exp=66", rx_data); end
        pop_one();
    endtask

    task automatic test_short_frame();
        int n;
        n = 0;
        converter_enable = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) scl_pulse(1'b1);
        converter_enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (frame_abort === 1'b1) n++;
        end
        checks++; if (n != 1) begin errors++; $display("FAIL abort_pulse_cycles got=%0d exp=1", n); end
        checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL abort_count got=%0d exp=0", rx_count); end
        send_byte(8'h3C);
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL after_abort_data got=%h exp=3c", rx_data); end
        checks++; if (rx_count !== 5'd1) begin errors++; $display("FAIL after_abort_count got=%0d exp=1", rx_count); end
        pop_one();
    endtask

    task automatic test_mid_byte_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        checks++; if (rx_count !== 5'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", rx_count); end
        converter_enable = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) scl_pulse(1'b1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", rx_empty); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL mid_byte_ready got=%b exp=0", byte_ready); end
        send_byte(8'hC3);
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL mid_next_data got=%h exp=c3", rx_data); end
        checks++; if (rx_count !== 5'd1) begin errors++; $display("FAIL mid_next_count got=%0d exp=1", rx_count); end
    endtask

    task automatic test_glitch();
        logic exp_rdy;
        logic [7:0] exp_dat;
`ifdef I2C_RX_GLITCH_FILTER_EN
        exp_rdy = 1'b0;
        exp_dat = 8'hFF;
`else
        exp_rdy = 1'b1;
        exp_dat = 8'h7F;
`endif
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        converter_enable = 1'b1;
        sda_in = 1'b0;
        tick(4);
        scl_in = 1'b1;
        tick(2);
        scl_in = 1'b0;
        tick(6);
        for (int i = 0; i < 7; i++) scl_pulse(1'b1);
        tick(2);
        checks++; if (byte_ready !== exp_rdy) begin errors++; $display("FAIL glitch_ready_after7 got=%b exp=%b", byte_ready, exp_rdy); end
        scl_pulse(1'b1);
        tick(2);
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL glitch_ready_after8 got=%b exp=1", byte_ready); end
        converter_enable = 1'b0;
        tick(1);
        commit_byte();
        checks++; if (rx_data !== exp_dat) begin errors++; $display("FAIL glitch_data got=%h exp=%h", rx_data, exp_dat); end
    endtask

    initial begin
        test_reset();
        test_byte_assembly();
        test_fill_overflow();
        test_simul_full();
        test_simul_empty();
        test_short_frame();
        test_mid_byte_reset();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
